// File: rtl/fetch_pkg.sv
// Shared defaults and entry-width helper for the instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_WIDTH_DEF  = 20;
  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_DEF       = 4;
  localparam int RESET_ADDR_DEF  = 0;
  localparam int ENTRY_W_DEF     = ADDR_WIDTH_DEF + INSTR_WIDTH_DEF;

  // A queue entry carries {pc, instruction word}.
  function automatic int entry_width(input int aw, input int iw);
    return aw + iw;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  // A full queue may still accept a push when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer/count next state; flush drops everything.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful under the count.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one-deep memory pipeline, redirect, fetch queue.
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_ADDR_DEF)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   jump_enable_i,
  input  logic [ADDR_WIDTH-1:0]  jump_address_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INSTR_WIDTH-1:0] out_instr_o,
  output logic [ADDR_WIDTH-1:0]  out_pc_o
);
  localparam int EW = entry_width(ADDR_WIDTH, INSTR_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, fpc_q, fpc_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         q_count;
  logic                  q_full, q_empty, room, push;
  logic [EW-1:0]         q_head;

  // Only request when the response is guaranteed a queue slot, counting the
  // one still in flight; pops this cycle are deliberately not credited.
  assign room        = (int'(q_count) + int'(inflight_q) + 1) <= DEPTH;
  assign imem_req_o  = reset_ni & ~jump_enable_i & ~q_full & room;
  assign imem_addr_o = pc_q;
  // A response arriving alongside a redirect belongs to the old stream.
  assign push        = inflight_q & ~jump_enable_i;

  // PC and in-flight tracking next state; redirect overrides sequencing.
  always_comb begin
    pc_d       = pc_q;
    fpc_d      = fpc_q;
    inflight_d = imem_req_o;
    if (imem_req_o) begin
      pc_d  = pc_q + ADDR_WIDTH'(1);
      fpc_d = pc_q;
    end
    if (jump_enable_i) pc_d = jump_address_i;
  end

  // PC / in-flight registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= RESET_ADDR;
      fpc_q      <= RESET_ADDR;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(EW)) u_queue (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .pop_i   (out_ready_i),
    .flush_i (jump_enable_i),
    .data_i  ({fpc_q, imem_rdata_i}),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign out_valid_o             = ~q_empty;
  assign {out_pc_o, out_instr_o} = q_head;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences, random scoreboard.
module tb_fetch_unit;
  localparam int AW = 20;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jump_enable = 1'b0;
  logic [AW-1:0] jump_address = '0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          imem_req, out_valid;
  logic [AW-1:0] imem_addr, out_pc;
  logic [IW-1:0] out_instr;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_ADDR(20'h0)) dut (
    .clock_i(clock), .reset_ni(reset), .jump_enable_i(jump_enable),
    .jump_address_i(jump_address), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_pc_o(out_pc)
  );

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return {12'hC5A, a};
  endfunction

  // Memory model: answers one cycle after a request, garbage otherwise.
  always @(posedge clock) imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0; jump_enable = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst req", 32'(imem_req), 32'(0));
    check("rst vld", 32'(out_valid), 32'(0));
    check("rst addr", 32'(imem_addr), 32'(0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic jmp; logic [AW-1:0] jaddr; logic rdy;
    logic e_req; logic [AW-1:0] e_addr; logic e_vld; logic [AW-1:0] e_pc;
  } vec_t;
  vec_t tbl[15];

  logic [AW-1:0] wexp[4];
  logic [AW-1:0] fpc, expc;
  int outst, pops, got;
  logic prev_jmp;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill with out_ready=0, drain, then redirect mid-stream.
    tbl[0]  = '{1'b0, 20'h0,     1'b0, 1'b1, 20'h0,     1'b0, 20'h0};
    tbl[1]  = '{1'b0, 20'h0,     1'b0, 1'b1, 20'h1,     1'b0, 20'h0};
    tbl[2]  = '{1'b0, 20'h0,     1'b0, 1'b1, 20'h2,     1'b1, 20'h0};
    tbl[3]  = '{1'b0, 20'h0,     1'b0, 1'b1, 20'h3,     1'b1, 20'h0};
    tbl[4]  = '{1'b0, 20'h0,     1'b0, 1'b0, 20'h4,     1'b1, 20'h0};
    tbl[5]  = '{1'b0, 20'h0,     1'b0, 1'b0, 20'h4,     1'b1, 20'h0};
    tbl[6]  = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h4,     1'b1, 20'h0};
    tbl[7]  = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h4,     1'b1, 20'h1};
    tbl[8]  = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h5,     1'b1, 20'h2};
    tbl[9]  = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h6,     1'b1, 20'h3};
    tbl[10] = '{1'b1, 20'h00F1F, 1'b1, 1'b0, 20'h7,     1'b1, 20'h4};
    tbl[11] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00F1F, 1'b0, 20'h0};
    tbl[12] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00F20, 1'b0, 20'h0};
    tbl[13] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00F21, 1'b1, 20'h00F1F};
    tbl[14] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00F22, 1'b1, 20'h00F20};

    reset_dut();
    for (int i = 0; i < 15; i++) begin
      jump_enable = tbl[i].jmp; jump_address = tbl[i].jaddr; out_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d vld", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check($sformatf("tbl%0d pc", i), 32'(out_pc), 32'(tbl[i].e_pc));
        check($sformatf("tbl%0d instr", i), out_instr, word_of(tbl[i].e_pc));
      end
      @(negedge clock);
    end
    jump_enable = 1'b0;

    // Redirect with 3 queued entries and one in flight.
    reset_dut();
    repeat (4) @(negedge clock);
    jump_enable = 1'b1; jump_address = 20'h00F1F;
    #1;
    check("jmp req low", 32'(imem_req), 32'(0));
    check("jmp pre vld", 32'(out_valid), 32'(1));
    @(negedge clock);
    jump_enable = 1'b0; out_ready = 1'b1;
    #1;
    check("jmp+1 vld", 32'(out_valid), 32'(0));
    check("jmp+1 addr", 32'(imem_addr), 32'(20'h00F1F));
    check("jmp+1 req", 32'(imem_req), 32'(1));
    @(negedge clock); #1;
    check("jmp+2 vld", 32'(out_valid), 32'(0));
    @(negedge clock); #1;
    check("jmp+3 vld", 32'(out_valid), 32'(1));
    check("jmp+3 pc", 32'(out_pc), 32'(20'h00F1F));

    // PC wrap across 2^AW.
    @(negedge clock);
    wexp[0] = 20'hFFFFE; wexp[1] = 20'hFFFFF; wexp[2] = 20'h00000; wexp[3] = 20'h00001;
    jump_enable = 1'b1; jump_address = 20'hFFFFE; out_ready = 1'b1;
    @(negedge clock);
    jump_enable = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #1;
      if (out_valid) begin
        check($sformatf("wrap pc%0d", got), 32'(out_pc), 32'(wexp[got]));
        got++;
      end
      @(negedge clock);
    end
    check("wrap count", 32'(got), 32'(4));

    // Asynchronous reset mid-stream with a partly full queue.
    reset_dut();
    repeat (3) @(negedge clock);
    #1;
    check("arst pre vld", 32'(out_valid), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("arst vld", 32'(out_valid), 32'(0));
    check("arst req", 32'(imem_req), 32'(0));
    check("arst addr", 32'(imem_addr), 32'(0));
    @(negedge clock);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    check("arst rel req", 32'(imem_req), 32'(1));
    check("arst rel addr", 32'(imem_addr), 32'(0));
    check("arst rel vld", 32'(out_valid), 32'(0));
    @(negedge clock); #1;
    check("arst c1 vld", 32'(out_valid), 32'(0));
    @(negedge clock); #1;
    check("arst c2 vld", 32'(out_valid), 32'(1));
    check("arst c2 pc", 32'(out_pc), 32'(0));
    check("arst c2 instr", out_instr, word_of(20'h0));
    @(negedge clock); #1;
    check("arst c3 pc", 32'(out_pc), 32'(1));

    // Random ready/redirects against an occupancy + sequence scoreboard.
    reset_dut();
    fpc = '0; expc = '0; outst = 0; pops = 0; prev_jmp = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      jump_enable  = ($urandom_range(0, 99) < 3);
      jump_address = AW'($urandom);
      out_ready    = 1'($urandom_range(0, 1));
      #1;
      if (prev_jmp) check("rnd vld after jump", 32'(out_valid), 32'(0));
      check("rnd req rule", 32'(imem_req), 32'(!jump_enable && (outst + 1 <= DEPTH)));
      if (imem_req) check("rnd addr", 32'(imem_addr), 32'(fpc));
      if (out_valid) begin
        check("rnd pc", 32'(out_pc), 32'(expc));
        check("rnd instr", out_instr, word_of(expc));
      end
      if (jump_enable) begin
        fpc = jump_address; expc = jump_address; outst = 0;
      end else begin
        if (imem_req) begin fpc = fpc + 1'b1; outst++; end
        if (out_valid && out_ready) begin expc = expc + 1'b1; outst--; pops++; end
      end
      check("rnd occupancy", 32'(outst >= 0 && outst <= DEPTH), 32'(1));
      prev_jmp = jump_enable;
      @(negedge clock);
    end
    check("rnd deliveries", 32'(pops >= 200), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
